// File: rtl/axi_pkg.sv
// Shared AXI read-port types and constants.
// Arbiter state encoding and AR field bundle.
package axi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AR   = 2'd1,
        ST_R    = 2'd2
    } arb_state_e;

    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [2:0] AXI_SIZE_WORD   = 3'b010;
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  id;
        logic [3:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
    } ar_req_t;

endpackage

// File: rtl/axi_read_arbiter.sv
// Shares one AXI read port between instruction fetch and data load.
// One outstanding transaction; R beats are routed to the owner by rid.
module axi_read_arbiter
    import axi_pkg::*;
#(
    parameter logic [3:0] INST_ID = 4'd0,
    parameter logic [3:0] DATA_ID = 4'd1
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    input  logic [3:0]  inst_len,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    output logic        inst_last,

    input  logic        data_req,
    input  logic [31:0] data_addr,
    input  logic [3:0]  data_len,
    input  logic [2:0]  data_size,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        data_last,

    output logic        arvalid,
    output logic [31:0] araddr,
    output logic [3:0]  arid,
    output logic [3:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    input  logic        arready,

    input  logic        rvalid,
    input  logic [31:0] rdata,
    input  logic [3:0]  rid,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    output logic        rready,

    output logic        rd_err,
    output logic        burst_err
);

    arb_state_e state_q, state_d;
    ar_req_t    ar_q, ar_d;
    logic       owner_q, owner_d;
    logic       last_data_q, last_data_d;
    logic [4:0] cnt_q, cnt_d;
    logic       rd_err_q, rd_err_d;
    logic       burst_err_q, burst_err_d;

    logic idle, gnt_inst, gnt_data;
    logic ar_hs, beat, hit, done, resp_err;

    assign idle     = (state_q == ST_IDLE);
    // Data wins a tie unless it was the last one served.
    assign gnt_data = idle & data_req & (~inst_req | ~last_data_q);
    assign gnt_inst = idle & inst_req & ~gnt_data;

    assign ar_hs    = (state_q == ST_AR) & arready;
    assign beat     = (state_q == ST_R) & rvalid;
    assign hit      = beat & (rid == ar_q.id);
    assign done     = hit & rlast;
    assign resp_err = (rresp == AXI_RESP_SLVERR) |
                      (rresp == AXI_RESP_DECERR);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (gnt_inst | gnt_data) state_d = ST_AR;
            ST_AR:   if (arready)             state_d = ST_R;
            ST_R:    if (done)                state_d = ST_IDLE;
            default:                          state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        arvalid      = (state_q == ST_AR);
        rready       = (state_q == ST_R);
        araddr       = ar_q.addr;
        arid         = ar_q.id;
        arlen        = ar_q.len;
        arsize       = ar_q.size;
        arburst      = ar_q.burst;
        arlock       = 2'b00;
        arcache      = 4'b0000;
        arprot       = 3'b000;
        inst_addr_ok = gnt_inst;
        data_addr_ok = gnt_data;
        inst_data_ok = hit & ~owner_q;
        data_data_ok = hit & owner_q;
        inst_rdata   = inst_data_ok ? rdata : 32'd0;
        data_rdata   = data_data_ok ? rdata : 32'd0;
        inst_last    = inst_data_ok & rlast;
        data_last    = data_data_ok & rlast;
        rd_err       = rd_err_q;
        burst_err    = burst_err_q;
    end

    always_comb begin
        ar_d        = ar_q;
        owner_d     = owner_q;
        last_data_d = last_data_q;
        cnt_d       = cnt_q;
        rd_err_d    = rd_err_q;
        burst_err_d = burst_err_q;
        if (gnt_inst) begin
            ar_d        = '{inst_addr, INST_ID, inst_len,
                            AXI_SIZE_WORD, AXI_BURST_INCR};
            owner_d     = 1'b0;
            last_data_d = 1'b0;
        end
        if (gnt_data) begin
            ar_d        = '{data_addr, DATA_ID, data_len,
                            data_size, AXI_BURST_INCR};
            owner_d     = 1'b1;
            last_data_d = 1'b1;
        end
        if (ar_hs) cnt_d = 5'd0;
        if (hit)   cnt_d = cnt_q + 5'd1;
        if (beat & resp_err) rd_err_d = 1'b1;
        // cnt_q excludes the current beat, so compare against len
        if (done & (cnt_q != {1'b0, ar_q.len})) burst_err_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ar_q        <= '0;
            owner_q     <= 1'b0;
            last_data_q <= 1'b0;
            cnt_q       <= 5'd0;
            rd_err_q    <= 1'b0;
            burst_err_q <= 1'b0;
        end else begin
            ar_q        <= ar_d;
            owner_q     <= owner_d;
            last_data_q <= last_data_d;
            cnt_q       <= cnt_d;
            rd_err_q    <= rd_err_d;
            burst_err_q <= burst_err_d;
        end
    end

endmodule

// File: doc/axi_read_arbiter.md
# axi_read_arbiter

Shares the core's single AXI read port between the instruction-fetch requester and the data-load requester. It replaces the ad-hoc `arvalid`/`neednewpc` logic at the top of the core. It accepts one request at a time from either side, drives the AR channel until the handshake completes, and routes R beats back to the owner until `rlast`. It sits between the IF/MEM stages and the AXI master ports of the core top.

## Interface
- Parameters:
- `INST_ID`, 4'd0: `arid` used for instruction reads.
- `DATA_ID`, 4'd1: `arid` used for data reads.
- Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `inst_req`  in  1  fetch request; held until `inst_addr_ok`.
- `inst_addr`  in  32  fetch byte address.
- `inst_len`  in  4  beats minus 1.
- `inst_addr_ok`  out  1  one-cycle grant pulse.
- `inst_data_ok`  out  1  beat valid to IF.
- `inst_rdata`  out  32  beat data.
- `inst_last`  out  1  final beat.
- `data_req`, `data_addr`[32], `data_len`[4], `data_size`[3]  in  data-load request, same rules as inst.
- `data_addr_ok`, `data_data_ok`, `data_rdata`[32], `data_last`  out  same meaning as the inst outputs, for data.
- `arvalid`  out  1  AR valid.
- `araddr`  out  32  AR address.
- `arid`  out  4  AR transaction ID.
- `arlen`  out  4  AR burst length minus 1.
- `arsize`  out  3  AR beat size.
- `arburst`  out  2  AR burst type.
- `arlock`  out  2  AR lock.
- `arcache`  out  4  AR cache.
- `arprot`  out  3  AR protection.
- `arready`  in  1  AR ready.
- `rvalid`  in  1  R valid.
- `rdata`  in  32  R data.
- `rid`  in  4  R transaction ID.
- `rresp`  in  2  R response.
- `rlast`  in  1  R last beat.
- `rready`  out  1  R ready.
- `rd_err`  out  1  sticky: SLVERR/DECERR seen.
- `burst_err`  out  1  sticky: beat count ≠ len+1 at `rlast`.

## Operation
- FSM states: IDLE, AR, R.
- IDLE:
  - If either req is high, grant one requester. Pulse its `*_addr_ok` combinationally in this cycle.
  - Latch AR fields into the registers, record the owner, go to AR.
- Arbitration:
  - Only one requester high: grant it.
  - Both high: grant the one not granted last. `last_grant` resets to INST, so data wins the first tie.
- AR fields:
  - Inst: `araddr`=`inst_addr`, `arlen`=`inst_len`, `arsize`=3'b010, `arid`=INST_ID.
  - Data: `araddr`=`data_addr`, `arlen`=`data_len`, `arsize`=`data_size`, `arid`=DATA_ID.
  - Always: `arburst`=2'b01 (INCR), `arlock`=0, `arcache`=0, `arprot`=0.
- AR:
  - `arvalid`=1 with stable fields until the cycle `arready`=1.
  - On that handshake: `arvalid` falls at the next edge, go to R, clear the beat counter.
- R:
  - `rready`=1.
  - Beat with `rvalid`=1 and `rid` equal to the owner's ID:
    - Owner `*_data_ok`=1 and `*_rdata`=`rdata`, passed through combinationally.
    - `*_last`=`rlast`.
    - Beat counter increments.
  - Beat with a mismatching `rid`: consumed, not forwarded.
  - `rresp[1]`=1 on any accepted beat sets `rd_err`.
  - Matching beat with `rlast`:
    - If the count including this beat ≠ `arlen`+1, set `burst_err`.
    - Return to IDLE. No new grant in this same cycle; earliest next `addr_ok` is the following cycle.
- Only one transaction is outstanding at a time; requests arriving in AR or R wait.
- Reset mid-transaction:
  - Returns immediately to IDLE.
  - Drops `arvalid` and `rready`.
  - Any in-flight burst is abandoned.

## Timing
- Reset values: all outputs 0, state IDLE, beat counter 0, `last_grant`=INST, sticky errors 0.
- `addr_ok` is combinational from req and state IDLE. The requester drops or changes req at the next edge.
- `arvalid` rises 1 cycle after the grant. Earliest AR handshake is the cycle after the grant.
- R beats forward with 0 added latency.
- Minimum turnaround for a single-beat read: grant cycle, AR cycle, R cycle, then back to IDLE for 1 cycle before the next grant, i.e. 3 busy cycles plus 1 IDLE.
- `data_ok` and `last` are never asserted outside R.

## Structure
- Shared package `axi_pkg`:
  - State encoding (IDLE/AR/R).
  - Constants: `AXI_BURST_INCR`=2'b01, `AXI_SIZE_WORD`=3'b010, `AXI_RESP_*`.
- No sub-module. Arbitration is a few lines inside the FSM.

## Test plan
- Inst only: `inst_req`, addr 0xBFC00000, len 0; `arready` after 2 cycles; 1 beat 0x3C080001 with `rlast` → `arlen`=0, `arsize`=2, `arid`=0; `inst_data_ok` and `inst_last` for 1 cycle; no data outputs.
- Simultaneous first request: inst 0x1000 len 3, data 0x2000 size 2 → data granted first (`arid`=1). Inst granted after data's `rlast`.
- 4-beat inst burst with `rvalid` gaps (beats 0xA,0xB,0xC,0xD, rlast on 4th) → exactly 4 `inst_data_ok` pulses in order; `burst_err`=0.
- Early `rlast` on beat 2 of a len=3 burst → `burst_err`=1 and stays 1; FSM back to IDLE.
- Beat with `rresp`=2'b10 → `rd_err`=1. A beat with a foreign `rid` is dropped with `rready`=1.
- Reset asserted in R mid-burst → `arvalid`=0, `rready`=0 and all ok outputs 0 immediately; a new request after reset release is granted normally.
